// File: rtl/notshazam_pkg.sv
// Shared constants and types for the landmark pairing stage (peak_pairer, peak_history).
package notshazam_pkg;

  localparam int unsigned PEAKS      = 6;
  localparam int unsigned FREQ_WIDTH = 4;
  localparam int unsigned AMPL_WIDTH = 32;
  localparam int unsigned TIME_WIDTH = 32;
  localparam int unsigned DT_WIDTH   = 6;
  localparam int unsigned HASH_WIDTH = 2 * FREQ_WIDTH + DT_WIDTH;
  localparam int unsigned PEAK_IDX_W = $clog2(PEAKS);
  // Wide enough for history depths up to 4 frames.
  localparam int unsigned HIST_CNT_W = 3;

  typedef struct packed {
    logic [PEAKS-1:0][AMPL_WIDTH-1:0] ampl;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0] freq;
    logic [TIME_WIDTH-1:0]            tstamp;
  } peak_frame_t;

  typedef struct packed {
    logic [FREQ_WIDTH-1:0] anchor_freq;
    logic [FREQ_WIDTH-1:0] target_freq;
    logic [DT_WIDTH-1:0]   dt;
  } hash_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StCommit
  } pp_state_e;

  // Frame distance clipped to the largest value the dt field can hold.
  function automatic logic [DT_WIDTH-1:0] sat_dt(input logic [TIME_WIDTH-1:0] diff);
    if (|diff[TIME_WIDTH-1:DT_WIDTH]) begin
      return '1;
    end
    return diff[DT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/peak_history.sv
// FAN_FRAMES-deep shift register of past peak frames, newest at index 0, with an
// indexed read port and a saturating count of valid entries.
module peak_history
  import notshazam_pkg::*;
#(
  parameter int unsigned FAN_FRAMES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  peak_frame_t           wr_frame_i,
  input  logic [HIST_CNT_W-1:0] rd_idx_i,
  output peak_frame_t           rd_frame_o,
  output logic [HIST_CNT_W-1:0] stored_o
);

  peak_frame_t           frames_q [FAN_FRAMES];
  peak_frame_t           frames_d [FAN_FRAMES];
  logic [HIST_CNT_W-1:0] stored_q, stored_d;

  always_comb begin
    frames_d = frames_q;
    stored_d = stored_q;
    if (wr_en_i) begin
      frames_d[0] = wr_frame_i;
      for (int i = 1; i < FAN_FRAMES; i++) begin
        frames_d[i] = frames_q[i-1];
      end
      if (stored_q < HIST_CNT_W'(FAN_FRAMES)) begin
        stored_d = stored_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frames_q <= '{default: '0};
      stored_q <= '0;
    end else begin
      frames_q <= frames_d;
      stored_q <= stored_d;
    end
  end

  always_comb begin
    rd_frame_o = '0;
    for (int i = 0; i < FAN_FRAMES; i++) begin
      if (rd_idx_i == HIST_CNT_W'(i)) begin
        rd_frame_o = frames_q[i];
      end
    end
  end

  assign stored_o = stored_q;

endmodule

// File: rtl/peak_pairer.sv
// Pairs each qualifying peak of a new frame with every qualifying peak of the last
// FAN_FRAMES frames and streams {anchor_freq, target_freq, dt} hash words.
// Optional build macro: PEAK_PAIRER_FREQ_WINDOW_EN limits pairs to a frequency window.
module peak_pairer
  import notshazam_pkg::*;
#(
  parameter int unsigned FAN_FRAMES  = 2,
  parameter int signed   MIN_AMPL    = 0,
  parameter int unsigned FREQ_WINDOW = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  input  logic [PEAKS-1:0][AMPL_WIDTH-1:0] amplitudes_in,
  input  logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs_in,
  input  logic [TIME_WIDTH-1:0]            counter_in,
  output logic [HASH_WIDTH-1:0]            hash_out,
  output logic [TIME_WIDTH-1:0]            anchor_time_out,
  output logic                             hash_valid,
  input  logic                             hash_ready,
  output logic                             busy,
  output logic [7:0]                       drop_count
);

  pp_state_e             state_q, state_d;
  logic                  pend_q, pend_d;
  peak_frame_t           frame_q, frame_d;
  logic [HIST_CNT_W-1:0] f_q, f_d;
  logic [PEAK_IDX_W-1:0] a_q, a_d, b_q, b_d;
  hash_word_t            hash_q, hash_d;
  logic [TIME_WIDTH-1:0] atime_q, atime_d;
  logic                  hvld_q, hvld_d;
  logic [7:0]            drop_q, drop_d;

  logic                  hist_wr;
  peak_frame_t           anchor;
  logic [HIST_CNT_W-1:0] stored;

  peak_history #(
    .FAN_FRAMES (FAN_FRAMES)
  ) u_history (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_en_i    (hist_wr),
    .wr_frame_i (frame_q),
    .rd_idx_i   (f_q),
    .rd_frame_o (anchor),
    .stored_o   (stored)
  );

  logic [FREQ_WIDTH-1:0] anc_freq, tgt_freq;
  logic                  amp_ok, win_ok, pair_ok;
  logic [TIME_WIDTH-1:0] t_diff;
  logic                  out_free;

  assign anc_freq = anchor.freq[a_q];
  assign tgt_freq = frame_q.freq[b_q];
  assign amp_ok   = ($signed(anchor.ampl[a_q]) > MIN_AMPL) &&
                    ($signed(frame_q.ampl[b_q]) > MIN_AMPL);
  // Modular subtraction keeps dt correct across a counter wrap.
  assign t_diff   = frame_q.tstamp - anchor.tstamp;

`ifdef PEAK_PAIRER_FREQ_WINDOW_EN
  logic [FREQ_WIDTH:0] anc_x, tgt_x, f_dist;
  assign anc_x  = {1'b0, anc_freq};
  assign tgt_x  = {1'b0, tgt_freq};
  assign f_dist = (tgt_x >= anc_x) ? (tgt_x - anc_x) : (anc_x - tgt_x);
  assign win_ok = (32'(f_dist) <= FREQ_WINDOW);
`else
  logic unused_freq_window;
  assign unused_freq_window = ^FREQ_WINDOW;
  assign win_ok = 1'b1;
`endif

  assign pair_ok  = amp_ok && win_ok;
  // The output slot is free unless a word is waiting for the consumer.
  assign out_free = !hvld_q || hash_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    frame_d = frame_q;
    f_d     = f_q;
    a_d     = a_q;
    b_d     = b_q;
    hash_d  = hash_q;
    atime_d = atime_q;
    hvld_d  = hvld_q;
    drop_d  = drop_q;
    hist_wr = 1'b0;

    if (valid_in && busy && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          // Setup cycle after capture: reset the indices and pick the path.
          pend_d  = 1'b0;
          f_d     = '0;
          a_d     = '0;
          b_d     = '0;
          state_d = (stored == '0) ? StCommit : StEmit;
        end else if (valid_in) begin
          frame_d = '{ampl: amplitudes_in, freq: freqs_in, tstamp: counter_in};
          pend_d  = 1'b1;
        end
      end
      StEmit: begin
        if (out_free) begin
          hvld_d = pair_ok;
          if (pair_ok) begin
            hash_d  = '{anchor_freq: anc_freq, target_freq: tgt_freq, dt: sat_dt(t_diff)};
            atime_d = anchor.tstamp;
          end
          if (b_q == PEAK_IDX_W'(PEAKS - 1)) begin
            b_d = '0;
            if (a_q == PEAK_IDX_W'(PEAKS - 1)) begin
              a_d = '0;
              if (f_q == stored - 1'b1) begin
                state_d = StCommit;
              end else begin
                f_d = f_q + 1'b1;
              end
            end else begin
              a_d = a_q + 1'b1;
            end
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      StCommit: begin
        // History is only updated once the final word has left.
        if (out_free) begin
          hvld_d  = 1'b0;
          hist_wr = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      frame_q <= '0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hash_q  <= '0;
      atime_q <= '0;
      hvld_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hash_q  <= hash_d;
      atime_q <= atime_d;
      hvld_q  <= hvld_d;
      drop_q  <= drop_d;
    end
  end

  assign hash_out        = hash_q;
  assign anchor_time_out = atime_q;
  assign hash_valid      = hvld_q;
  assign busy            = pend_q || (state_q != StIdle);
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_peak_pairer.sv
// Self-checking bench for peak_pairer: directed table, stall/drop/reset sequences and
// randomized frames checked against a list-based reference model.
module tb_peak_pairer;
  import notshazam_pkg::*;

  localparam int unsigned FAN = 2;

  logic                             clk = 1'b0;
  logic                             reset;
  logic                             valid_in;
  logic [PEAKS-1:0][AMPL_WIDTH-1:0] amplitudes_in;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs_in;
  logic [TIME_WIDTH-1:0]            counter_in;
  logic [HASH_WIDTH-1:0]            hash_out;
  logic [TIME_WIDTH-1:0]            anchor_time_out;
  logic                             hash_valid;
  logic                             hash_ready;
  logic                             busy;
  logic [7:0]                       drop_count;

  peak_pairer #(
    .FAN_FRAMES  (FAN),
    .MIN_AMPL    (0),
    .FREQ_WINDOW (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .amplitudes_in   (amplitudes_in),
    .freqs_in        (freqs_in),
    .counter_in      (counter_in),
    .hash_out        (hash_out),
    .anchor_time_out (anchor_time_out),
    .hash_valid      (hash_valid),
    .hash_ready      (hash_ready),
    .busy            (busy),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          amp[6];
    int          fq[6];
    logic [31:0] t;
  } frame_m_t;

  typedef struct {
    logic [13:0] h;
    logic [31:0] t;
  } exp_t;

  typedef struct {
    bit          do_reset;
    int          amp[6];
    int          fq[6];
    logic [31:0] t;
    int          n_hash;
    logic [13:0] first_h;
    logic [31:0] first_t;
    int          busy_cyc;
  } vec_t;

  frame_m_t hist[$];
  exp_t     expq[$];
  int       exp_drop;
  int       n_err;
  int       n_checks;

  int stall_from, stall_len, drop_k1, drop_k2;
  bit rand_ready;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: list every anchor/target pair in emission order, then age the history.
  function automatic void model_frame(input frame_m_t fr);
    logic [31:0] d;
    int          dt;
    bit          ok;
    exp_t        e;
    for (int f = 0; f < hist.size(); f++) begin
      for (int a = 0; a < PEAKS; a++) begin
        for (int b = 0; b < PEAKS; b++) begin
          ok = (hist[f].amp[a] > 0) && (fr.amp[b] > 0);
`ifdef PEAK_PAIRER_FREQ_WINDOW_EN
          ok = ok && ((hist[f].fq[a] - fr.fq[b] <= 4) && (fr.fq[b] - hist[f].fq[a] <= 4));
`endif
          if (ok) begin
            d   = fr.t - hist[f].t;
            dt  = (d > 32'd63) ? 63 : int'(d);
            e.h = {4'(hist[f].fq[a]), 4'(fr.fq[b]), 6'(dt)};
            e.t = hist[f].t;
            expq.push_back(e);
          end
        end
      end
    end
    hist.push_front(fr);
    if (hist.size() > FAN) hist.pop_back();
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hash_out"}, 64'(hash_out), 64'd0);
    chk({tag, "_anchor_time"}, 64'(anchor_time_out), 64'd0);
    chk({tag, "_hash_valid"}, 64'(hash_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    expq.delete();
    exp_drop = 0;
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
  endtask

  task automatic send_frame(input frame_m_t fr, input int abort_k, output int nseen,
                            output logic [13:0] first_h, output logic [31:0] first_t,
                            output int bcyc);
    int          exp_busy;
    bit          stalled;
    bit          done;
    logic [13:0] ph;
    logic [31:0] pt;
    exp_t        e;
    nseen = 0; bcyc = 0; first_h = '0; first_t = '0;
    stalled = 1'b0; done = 1'b0; ph = '0; pt = '0;
    @(negedge clk);
    for (int i = 0; i < PEAKS; i++) begin
      amplitudes_in[i] = 32'(fr.amp[i]);
      freqs_in[i]      = 4'(fr.fq[i]);
    end
    counter_in = fr.t;
    valid_in   = 1'b1;
    exp_busy   = 2 + hist.size() * PEAKS * PEAKS;
    model_frame(fr);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (k == abort_k) return;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      bcyc++;
      if (k == drop_k1 || k == drop_k2) begin
        valid_in         = 1'b1;
        amplitudes_in[0] = $urandom;
        counter_in       = $urandom;
        if (exp_drop < 255) exp_drop++;
      end
      hash_ready = rand_ready ? 1'($urandom_range(0, 1))
                              : !(k >= stall_from && k < stall_from + stall_len);
      if (stalled) begin
        chk("hold", {17'd0, hash_valid, hash_out, anchor_time_out}, {17'd0, 1'b1, ph, pt});
      end
      stalled = 1'b0;
      if (hash_valid) begin
        if (hash_ready) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL extra_word: got hash 0x%0h, expected no word", hash_out);
          end else begin
            e = expq.pop_front();
            chk("hash", 64'(hash_out), 64'(e.h));
            chk("anchor_time", 64'(anchor_time_out), 64'(e.t));
          end
          if (nseen == 0) begin
            first_h = hash_out;
            first_t = anchor_time_out;
          end
          nseen++;
        end else begin
          stalled = 1'b1;
          ph = hash_out;
          pt = anchor_time_out;
        end
      end
    end
    valid_in   = 1'b0;
    hash_ready = 1'b1;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_timeout: busy still %0b after 4000 cycles, expected 0", busy);
    end
    chk("pending_words", 64'(expq.size()), 64'd0);
    chk("drop_count", 64'(drop_count), 64'(exp_drop));
    if (stall_len == 0 && !rand_ready) chk("busy_cycles", 64'(bcyc), 64'(exp_busy));
  endtask

  vec_t        vecs[7];
  frame_m_t    fr;
  int          nseen, bcyc;
  logic [13:0] fh;
  logic [31:0] ft, tcur;

  initial begin
    n_err = 0; n_checks = 0; exp_drop = 0;
    reset = 1'b0; valid_in = 1'b0; hash_ready = 1'b1;
    amplitudes_in = '0; freqs_in = '0; counter_in = '0;
    stall_from = 0; stall_len = 0; drop_k1 = -1; drop_k2 = -1; rand_ready = 1'b0;

    vecs[0] = '{1'b1, '{9, 0, 0, 0, 0, 0}, '{1, 3, 5, 8, 12, 15}, 32'd10, 0, 14'd0, 32'd0, 2};
    vecs[1] = '{1'b0, '{7, 0, 0, 0, 0, 0}, '{2, 4, 6, 9, 13, 14}, 32'd11, 1, 14'd1153, 32'd10, 38};
    vecs[2] = '{1'b1, '{5, 5, 5, 5, 5, 5}, '{1, 3, 5, 8, 12, 15}, 32'd10, 0, 14'd0, 32'd0, 2};
    vecs[3] = '{1'b0, '{5, 5, 5, 5, 5, 5}, '{2, 4, 6, 9, 13, 14}, 32'd11, 36, 14'd1153, 32'd10, 38};
    vecs[4] = '{1'b0, '{5, 5, 5, 5, 5, 5}, '{0, 7, 7, 3, 15, 10}, 32'd12, 72, 14'd2049, 32'd11, 74};
    vecs[5] = '{1'b1, '{5, 5, 5, 5, 5, 5}, '{1, 3, 5, 8, 12, 15}, 32'hFFFF_FFFF, 0, 14'd0, 32'd0, 2};
    vecs[6] = '{1'b0, '{5, 5, 5, 5, 5, 5}, '{2, 4, 6, 9, 13, 14}, 32'h40, 36, 14'd1215,
                32'hFFFF_FFFF, 38};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_reset) do_reset();
      fr.amp = vecs[v].amp;
      fr.fq  = vecs[v].fq;
      fr.t   = vecs[v].t;
      send_frame(fr, -1, nseen, fh, ft, bcyc);
      chk($sformatf("vec%0d_nhash", v), 64'(nseen), 64'(vecs[v].n_hash));
      chk($sformatf("vec%0d_busy", v), 64'(bcyc), 64'(vecs[v].busy_cyc));
      if (vecs[v].n_hash > 0) begin
        chk($sformatf("vec%0d_first_hash", v), 64'(fh), 64'(vecs[v].first_h));
        chk($sformatf("vec%0d_first_time", v), 64'(ft), 64'(vecs[v].first_t));
      end
    end

    // Backpressure for 5 cycles mid-stream plus two dropped frames during EMIT.
    do_reset();
    fr.amp = '{5, 5, 5, 5, 5, 5};
    fr.fq = '{1, 3, 5, 8, 12, 15}; fr.t = 32'd100; send_frame(fr, -1, nseen, fh, ft, bcyc);
    fr.fq = '{2, 4, 6, 9, 13, 14}; fr.t = 32'd101; send_frame(fr, -1, nseen, fh, ft, bcyc);
    stall_from = 20; stall_len = 5; drop_k1 = 5; drop_k2 = 30;
    fr.fq = '{0, 7, 7, 3, 15, 10}; fr.t = 32'd102; send_frame(fr, -1, nseen, fh, ft, bcyc);
    chk("stall_nhash", 64'(nseen), 64'd72);
    chk("stall_drops", 64'(drop_count), 64'd2);
    chk("stall_busy", 64'(bcyc), 64'd79);
    stall_from = 0; stall_len = 0; drop_k1 = -1; drop_k2 = -1;

    // Randomized frames with random backpressure and stray valid_in pulses.
    do_reset();
    rand_ready = 1'b1;
    tcur = 32'hFFFF_FFC0;
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < PEAKS; i++) begin
        fr.amp[i] = ($urandom_range(0, 3) == 0) ? -int'($urandom_range(0, 5))
                                                : int'($urandom_range(1, 1000));
        fr.fq[i]  = int'($urandom_range(0, 15));
      end
      tcur += 32'($urandom_range(1, 80));
      fr.t = tcur;
      drop_k1 = int'($urandom_range(0, 60));
      send_frame(fr, -1, nseen, fh, ft, bcyc);
    end
    rand_ready = 1'b0;
    drop_k1 = -1;

    // Reset in the middle of EMIT: outputs clear at once and history is empty afterwards.
    do_reset();
    fr.amp = '{5, 5, 5, 5, 5, 5};
    fr.fq = '{1, 3, 5, 8, 12, 15}; fr.t = 32'd200; send_frame(fr, -1, nseen, fh, ft, bcyc);
    fr.fq = '{2, 4, 6, 9, 13, 14}; fr.t = 32'd201; send_frame(fr, -1, nseen, fh, ft, bcyc);
    drop_k1 = 3;
    fr.fq = '{0, 7, 7, 3, 15, 10}; fr.t = 32'd202; send_frame(fr, 10, nseen, fh, ft, bcyc);
    drop_k1 = -1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    hist.delete();
    expq.delete();
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b1;
    fr.fq = '{4, 4, 4, 4, 4, 4}; fr.t = 32'd203; send_frame(fr, -1, nseen, fh, ft, bcyc);
    chk("after_reset_nhash", 64'(nseen), 64'd0);
    chk("after_reset_busy", 64'(bcyc), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
